mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit and HI/LO controller for the pipelined MIPS core.
- Sits beside the ALU in the E stage and sequences mult/multu/div/divu over a fixed latency.
- Owns the HI/LO registers and serves mthi/mtlo writes.
- Generates the D-stage stall request that holds back MDU instructions while an operation is in flight.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_arith.sv | 74 +++++++
 rtl/mdu_ctrl.sv | 135 +++++++++++++
 tb/tb_mdu_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit. Holds the
//               3-bit MDU op encodings, the controller state encoding, the
//               busy-counter width and small op-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Width of the busy-cycle down-counter; MULT_CYCLES and DIV_CYCLES must
  // both fit in it.
  localparam int CNT_W = 4;

  // MDU op encodings as presented by the E stage.
  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_RSVD  = 3'd7;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // True for the multiply family (mult/multu).
  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  // True for the divide family (div/divu).
  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Purely combinational arithmetic core of the MDU. Produces the
//               64-bit {hi,lo} result for the latched op and operands and
//               flags a divide by zero so the controller can suppress the
//               HI/LO write.
// Ports       : op          - latched MDU op
//               a, b        - latched rs / rt operands
//               result      - {hi,lo}: product, or {remainder,quotient}
//               div_by_zero - divide op with b == 0
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  always_comb begin
    // Signed divide is done on magnitudes with one shared unsigned divider;
    // signs are restored afterwards. 0x80000000 / -1 falls out naturally:
    // the magnitude quotient 0x80000000 keeps its bit pattern and the
    // remainder is 0.
    w_signed_div  = (op == MDU_DIV);
    w_a_neg       = w_signed_div & a[31];
    w_b_neg       = w_signed_div & b[31];
    w_dividend    = w_a_neg ? (32'd0 - a) : a;
    w_divisor_mag = w_b_neg ? (32'd0 - b) : b;
    // Substitute 1 for a zero divisor so the divider output stays defined;
    // the result is discarded in that case anyway.
    w_divisor     = (w_divisor_mag == 32'd0) ? 32'd1 : w_divisor_mag;
    w_q_mag       = w_dividend / w_divisor;
    w_r_mag       = w_dividend % w_divisor;
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    w_q           = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_r           = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Low 64 bits of the product of sign-extended operands is the signed
    // 32x32 product.
    w_prod_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    w_prod_u      = {32'd0, a} * {32'd0, b};

    div_by_zero   = is_div(op) && (b == 32'd0);

    result = 64'd0;
    case (op)
      MDU_MULT:  result = w_prod_s;
      MDU_MULTU: result = w_prod_u;
      MDU_DIV,
      MDU_DIVU:  result = {w_r, w_q};
      default:   result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle multiply/divide controller and HI/LO owner for the
//               E stage. Sequences mult/multu/div/divu over a fixed latency,
//               serves mthi/mtlo and raises the D-stage stall request.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous active-low reset
//               start  - E-stage MDU instruction valid
//               op     - MDU op (see mdu_pkg)
//               a, b   - forwarded rs / rt operands
//               d_md   - D-stage instruction is an MDU instruction
//               busy   - operation in flight
//               hi, lo - HI / LO registers
//               stall  - D-stage stall request
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall
);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;

  logic [63:0]      w_result;
  logic             w_div_by_zero;

  // Result is always derived from the operands captured at start, so the
  // forwarded a/b are free to change while the operation runs.
  mdu_arith u_arith (
    .op          (r_op),
    .a           (r_a),
    .b           (r_b),
    .result      (w_result),
    .div_by_zero (w_div_by_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_op    <= MDU_NONE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                r_state <= ST_MUL;
                r_cnt   <= C_MULT_CNT;
                r_busy  <= 1'b1;
                r_op    <= op;
                r_a     <= a;
                r_b     <= b;
              end
              MDU_DIV, MDU_DIVU: begin
                r_state <= ST_DIV;
                r_cnt   <= C_DIV_CNT;
                r_busy  <= 1'b1;
                r_op    <= op;
                r_a     <= a;
                r_b     <= b;
              end
              MDU_MTHI: r_hi <= a;
              MDU_MTLO: r_lo <= a;
              MDU_NONE, MDU_RSVD: ;
              default: ;
            endcase
          end
        end

        // A start seen here is ignored: the hazard unit never issues one.
        ST_MUL, ST_DIV: begin
          // Final busy cycle: commit the result and drop busy on the same
          // edge so new HI/LO appear together with busy == 0. The <= guard
          // also recovers from a counter that was somehow left at zero.
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (!w_div_by_zero) begin
              r_hi <= w_result[63:32];
              r_lo <= w_result[31:0];
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  // The start term covers the issue cycle, before busy has been registered.
  assign stall = d_md && (r_busy || (start && (is_mul(op) || is_div(op))));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl. Directed scenarios plus
//               randomized ops checked against a behavioural HI/LO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;

  int          vectors;
  int          errors;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .d_md  (d_md),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural model: applies one op to HI/LO and returns the number of
  // busy cycles the op must produce.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, output int n);
    longint      sx, sy, q, r;
    logic [63:0] p;
    n = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT: begin
        p = 64'(sx * sy);
        m_hi = p[63:32]; m_lo = p[31:0]; n = MULT_CYCLES;
      end
      OP_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        m_hi = p[63:32]; m_lo = p[31:0]; n = MULT_CYCLES;
      end
      OP_DIV: begin
        if (y != 32'd0) begin
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        n = DIV_CYCLES;
      end
      OP_DIVU: begin
        if (y != 32'd0) begin
          m_lo = x / y; m_hi = x % y;
        end
        n = DIV_CYCLES;
      end
      OP_MTHI: m_hi = x;
      OP_MTLO: m_lo = x;
      default: ;
    endcase
  endtask

  // Issue one op, scramble the live operands, then count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int ncyc);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 64) begin
      ncyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0; start = 1'b0; op = OP_NONE; a = '0; b = '0; d_md = 1'b0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    reset = 1'b1;
    tick();
    // Load nonzero HI/LO so that clearing by reset is observable.
    run_op(OP_MTHI, 32'hCAFE0001, 32'd0, n); model_apply(OP_MTHI, 32'hCAFE0001, 32'd0, n);
    run_op(OP_MTLO, 32'hCAFE0002, 32'd0, n); model_apply(OP_MTLO, 32'hCAFE0002, 32'd0, n);
    // Start a DIV and abort it in its 4th busy cycle.
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_prebusy: got %b expected 1", busy); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h expected 0", hi); end
    vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h expected 0", lo); end
    tick();
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < 12; i++) tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_late_busy: got %b expected 0", busy); end
    vectors++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_late_hilo: got %h expected 0", {hi, lo}); end
  endtask

  task automatic test_mult();
    int n, e;
    model_apply(OP_MULT, 32'hFFFFFFFD, 32'd5, e);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, n);
    vectors++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
    model_apply(OP_MULTU, 32'hFFFFFFFF, 32'd2, e);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, n);
    vectors++; if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
    vectors++; if (hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    vectors++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
  endtask

  task automatic test_div();
    int n, e;
    model_apply(OP_DIV, 32'hFFFFFFF9, 32'd2, e);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
    vectors++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
    vectors++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    model_apply(OP_DIVU, 32'd7, 32'd0, e);
    run_op(OP_DIVU, 32'd7, 32'd0, n);
    vectors++; if (n !== 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d expected 10", n); end
    vectors++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL divz_hilo: got %h expected ffffffff_fffffffd", {hi, lo}); end
    model_apply(OP_DIV, 32'h80000000, 32'hFFFFFFFF, e);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    vectors++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    vectors++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int e;
    start = 1'b1; op = OP_MTHI; a = 32'h12345678;
    tick();
    vectors++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    op = OP_MTLO; a = 32'h9ABCDEF0;
    tick();
    start = 1'b0;
    vectors++; if (lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo: got %h expected 9abcdef0", lo); end
    vectors++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
    model_apply(OP_MTHI, 32'h12345678, 32'd0, e);
    model_apply(OP_MTLO, 32'h9ABCDEF0, 32'd0, e);
  endtask

  task automatic test_start_while_busy();
    int cnt, e;
    model_apply(OP_MULT, 32'd3, 32'd4, e);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    tick();
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      start = 1'b1;
      op = (cnt % 3 == 1) ? OP_DIV : (cnt % 3 == 2) ? OP_MTHI : OP_MTLO;
      a = 32'hDEAD0000 | 32'(cnt); b = 32'd7;
      tick();
    end
    start = 1'b0;
    vectors++; if (cnt !== MULT_CYCLES) begin errors++; $display("FAIL swb_busy_cycles: got %0d expected %0d", cnt, MULT_CYCLES); end
    vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL swb_hilo: got %h expected %h", {hi, lo}, {m_hi, m_lo}); end
    tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL swb_after_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stall();
    int cnt, e;
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    model_apply(OP_MULT, x, y, e);
    d_md = 1'b1; start = 1'b1; op = OP_MULT; a = x; b = y;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (stall === 1'b1) cnt++;
      tick();
      start = 1'b0;
    end
    vectors++; if (cnt !== 6) begin errors++; $display("FAIL stall_dmd1_cycles: got %0d expected 6", cnt); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after: got %b expected 0", stall); end
    vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL stall_mult_hilo: got %h expected %h", {hi, lo}, {m_hi, m_lo}); end
    start = 1'b1; op = OP_MTHI; a = 32'h0BADF00D;
    #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_mthi: got %b expected 0", stall); end
    tick();
    model_apply(OP_MTHI, 32'h0BADF00D, 32'd0, e);
    x = $urandom; y = $urandom;
    model_apply(OP_DIVU, x, y, e);
    d_md = 1'b0; start = 1'b1; op = OP_DIVU; a = x; b = y;
    cnt = 0;
    for (int i = 0; i < 13; i++) begin
      #1;
      if (stall !== 1'b0) cnt++;
      tick();
      start = 1'b0;
    end
    vectors++; if (cnt !== 0) begin errors++; $display("FAIL stall_dmd0_cycles: got %0d expected 0", cnt); end
  endtask

  task automatic test_random();
    int n, e;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 9));
        3: y = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      model_apply(o, x, y, e);
      run_op(o, x, y, n);
      vectors++; if (n !== e) begin errors++; $display("FAIL rand_busy[%0d] op=%0d: got %0d expected %0d", i, o, n, e); end
      vectors++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, {hi, lo}, {m_hi, m_lo}); end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_start_while_busy();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
